// File: rtl/chinpo_pkg.sv
// Shared types and constants for the CHINPO memory access sequencer.
package chinpo_pkg;

  localparam int WORD_W = 16;
  localparam int OPC_W  = 4;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Latched access kind
  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    for (int i = 1; i <= 5; i++) begin
      if (max_val >= (1 << i)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  // True when two or more request strobes are raised together
  function automatic logic multi_req(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/chinpo_wait_counter.sv
// Loadable down-counter that times the memory settle cycles of one access.
module chinpo_wait_counter
  import chinpo_pkg::*;
#(
  parameter int CNT_W = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load takes precedence; decrement only while non-zero so the count never wraps
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/chinpo_mem_interface.sv
// Memory access sequencer: turns control-FSM strobes into timed memory
// transactions, stalls the control FSM while busy, and owns IR/MDR.
module chinpo_mem_interface
  import chinpo_pkg::*;
#(
  parameter int WORD_W      = chinpo_pkg::WORD_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IRWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemAddr,
  input  logic [WORD_W-1:0] PC_in,
  input  logic [WORD_W-1:0] ALUOut_in,
  input  logic [WORD_W-1:0] WData_in,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic              Stall,
  output logic [WORD_W-1:0] IR,
  output logic [WORD_W-1:0] MDR,
  output logic [OPC_W-1:0]  Opcode,
  output logic              IR3,
  output logic              IR2,
  output logic              IR1,
  output logic              IR0,
  output logic              ProtoErr
);

  localparam int CNT_W = cnt_width(WAIT_STATES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_STATES);

  state_t            r_state;
  state_t            w_next_state;
  op_t               r_op;
  op_t               w_op_sel;
  op_t               w_op_next;
  logic [WORD_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_mdr;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_proto_err;
  logic              w_req;
  logic              w_start;
  logic              w_finish;
  logic              w_load;
  logic              w_dec;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_zero;

  assign w_req    = IRWrite | MemRead | MemWrite;
  assign w_start  = (r_state == ST_IDLE) && w_req;
  assign w_finish = (r_state == ST_BUSY) && w_cnt_zero;

  chinpo_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .CLK        (CLK),
    .Reset      (Reset),
    .i_load     (w_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (w_dec),
    .o_cnt      (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // Request priority: a write wins over a read, a read over a fetch
  always_comb begin
    w_op_sel = OP_FETCH;
    if (MemWrite) begin
      w_op_sel = OP_WRITE;
    end else if (MemRead) begin
      w_op_sel = OP_READ;
    end else begin
      w_op_sel = OP_FETCH;
    end
  end

  // Operation that will be in force next cycle, used to pre-register mem_we
  always_comb begin
    w_op_next = r_op;
    if (r_state == ST_IDLE) begin
      w_op_next = w_op_sel;
    end else begin
      w_op_next = r_op;
    end
  end

  // Next-state logic and wait-counter control
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next_state = ST_BUSY;
          w_load       = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (w_cnt_zero) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_BUSY;
          w_dec        = 1'b1;
        end
      end
      // Strobes are ignored here so a still-held request cannot retrigger
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latch the access kind, address and store data when a request is accepted
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_op        <= OP_FETCH;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start) begin
      r_op        <= w_op_sel;
      r_mem_addr  <= MemAddr ? ALUOut_in : PC_in;
      r_mem_wdata <= WData_in;
    end else begin
      r_op        <= r_op;
      r_mem_addr  <= r_mem_addr;
      r_mem_wdata <= r_mem_wdata;
    end
  end

  // Memory strobes are registered so they are high exactly during BUSY
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      r_mem_en <= (w_next_state == ST_BUSY);
      r_mem_we <= (w_next_state == ST_BUSY) && (w_op_next == OP_WRITE);
    end
  end

  // Capture read data on the last settle edge; writes leave IR and MDR alone
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_ir  <= '0;
      r_mdr <= '0;
    end else if (w_finish && (r_op == OP_FETCH)) begin
      r_ir  <= mem_rdata;
      r_mdr <= r_mdr;
    end else if (w_finish && (r_op == OP_READ)) begin
      r_ir  <= r_ir;
      r_mdr <= mem_rdata;
    end else begin
      r_ir  <= r_ir;
      r_mdr <= r_mdr;
    end
  end

  // Sticky protocol error: more than one strobe offered in the same request
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_proto_err <= 1'b0;
    end else if (w_start && multi_req(IRWrite, MemRead, MemWrite)) begin
      r_proto_err <= 1'b1;
    end else begin
      r_proto_err <= r_proto_err;
    end
  end

  // Stall must rise in the request cycle, so it is decoded combinationally
  assign Stall     = !Reset && (w_start || (r_state == ST_BUSY));
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign IR        = r_ir;
  assign MDR       = r_mdr;
  assign Opcode    = r_ir[WORD_W-1 -: OPC_W];
  assign IR3       = r_ir[3];
  assign IR2       = r_ir[2];
  assign IR1       = r_ir[1];
  assign IR0       = r_ir[0];
  assign ProtoErr  = r_proto_err;

endmodule

// File: tb/tb_chinpo_mem_interface.sv
// Directed self-checking bench: three sequencer instances (WAIT_STATES 1, 3, 0),
// each with its own behavioural memory.
module tb_chinpo_mem_interface;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        irw [3];
  logic        mrd [3];
  logic        mwr [3];
  logic        msel [3];
  logic [15:0] pc [3];
  logic [15:0] alu [3];
  logic [15:0] wd [3];
  logic [15:0] rdata [3];
  logic [15:0] maddr [3];
  logic [15:0] mwdata [3];
  logic [15:0] ir [3];
  logic [15:0] mdr [3];
  logic [3:0]  opc [3];
  logic        en [3];
  logic        we [3];
  logic        stall [3];
  logic        perr [3];
  logic        ir3 [3];
  logic        ir2 [3];
  logic        ir1 [3];
  logic        ir0 [3];
  logic [15:0] mem [3][256];
  logic        pre_we = 1'b0;
  int          pre_g = 0;
  logic [7:0]  pre_a = 8'h00;
  logic [15:0] pre_d = 16'h0000;
  int          passed = 0;
  int          total = 0;

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    chinpo_mem_interface #(.WORD_W(16), .WAIT_STATES(WS)) u_dut (
      .CLK(CLK), .Reset(Reset), .IRWrite(irw[g]), .MemRead(mrd[g]), .MemWrite(mwr[g]),
      .MemAddr(msel[g]), .PC_in(pc[g]), .ALUOut_in(alu[g]), .WData_in(wd[g]),
      .mem_rdata(rdata[g]), .mem_addr(maddr[g]), .mem_wdata(mwdata[g]), .mem_en(en[g]),
      .mem_we(we[g]), .Stall(stall[g]), .IR(ir[g]), .MDR(mdr[g]), .Opcode(opc[g]),
      .IR3(ir3[g]), .IR2(ir2[g]), .IR1(ir1[g]), .IR0(ir0[g]), .ProtoErr(perr[g]));
    assign rdata[g] = mem[g][maddr[g][7:0]];
  end

  // Memory model: bench preload port plus DUT writes
  always @(posedge CLK) begin
    if (pre_we) mem[pre_g][pre_a] <= pre_d;
    for (int g = 0; g < 3; g++) begin
      if (en[g] && we[g]) mem[g][maddr[g][7:0]] <= mwdata[g];
    end
  end

  task automatic preload(input int g, input logic [7:0] a, input logic [15:0] d);
    @(negedge CLK);
    pre_g = g; pre_a = a; pre_d = d; pre_we = 1'b1;
    @(negedge CLK);
    pre_we = 1'b0;
  endtask

  task automatic drop_strobes(input int g);
    irw[g] = 1'b0; mrd[g] = 1'b0; mwr[g] = 1'b0;
  endtask

  // One access observed over 8 cycles; strobes dropped at cycle 'hold'
  task automatic run_access(input int g, input logic iw, input logic mr, input logic mw,
                            input logic ma, input logic [15:0] p, input logic [15:0] a,
                            input logic [15:0] d, input int hold, input logic [15:0] exp_addr,
                            output int n_stall, output int n_en, output int n_we,
                            output int n_bad, output logic [15:0] ir_done,
                            output logic [15:0] mdr_done);
    logic seen;
    logic got;
    n_stall = 0; n_en = 0; n_we = 0; n_bad = 0; seen = 1'b0; got = 1'b0;
    ir_done = 16'hxxxx; mdr_done = 16'hxxxx;
    @(negedge CLK);
    irw[g] = iw; mrd[g] = mr; mwr[g] = mw; msel[g] = ma; pc[g] = p; alu[g] = a; wd[g] = d;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == hold) drop_strobes(g);
      #1;
      if (stall[g]) begin
        n_stall++; seen = 1'b1;
      end else if (seen && !got) begin
        got = 1'b1; ir_done = ir[g]; mdr_done = mdr[g];
      end
      if (en[g]) begin
        n_en++;
        if (maddr[g] !== exp_addr) n_bad++;
        if (we[g]) begin
          n_we++;
          if (mwdata[g] !== d) n_bad++;
        end
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      drop_strobes(g); msel[g] = 1'b0; pc[g] = 16'h0; alu[g] = 16'h0; wd[g] = 16'h0;
    end
    repeat (2) @(negedge CLK);
    irw[0] = 1'b1;
    #1;
    total++; if (stall[0] !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall[0]); else passed++;
    total++; if ({ir[0], mdr[0]} !== 32'h0) $display("FAIL reset_ir_mdr: got %h expected 0", {ir[0], mdr[0]}); else passed++;
    total++; if ({maddr[0], mwdata[0]} !== 32'h0) $display("FAIL reset_addr_wdata: got %h expected 0", {maddr[0], mwdata[0]}); else passed++;
    total++; if ({en[0], we[0], perr[0]} !== 3'b000) $display("FAIL reset_en_we_perr: got %b expected 000", {en[0], we[0], perr[0]}); else passed++;
    irw[0] = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_fetch;
    int ns, ne, nw, nb;
    logic [15:0] ird, mdd;
    preload(0, 8'h10, 16'hF123);
    run_access(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h0010, ns, ne, nw, nb, ird, mdd);
    total++; if (ns !== 3) $display("FAIL fetch_stall_cycles: got %0d expected 3", ns); else passed++;
    total++; if (ne !== 2) $display("FAIL fetch_en_cycles: got %0d expected 2", ne); else passed++;
    total++; if (nw !== 0 || nb !== 0) $display("FAIL fetch_bus: got we=%0d bad=%0d expected 0/0", nw, nb); else passed++;
    total++; if (ird !== 16'hF123) $display("FAIL fetch_ir_done: got %h expected f123", ird); else passed++;
    total++; if (opc[0] !== 4'hF) $display("FAIL fetch_opcode: got %h expected f", opc[0]); else passed++;
    total++; if ({ir3[0], ir2[0], ir1[0], ir0[0]} !== 4'b0011) $display("FAIL fetch_ir_bits: got %b expected 0011", {ir3[0], ir2[0], ir1[0], ir0[0]}); else passed++;
  endtask

  task automatic test_read_held;
    int ns, ne, nw, nb;
    logic [15:0] ird, mdd;
    preload(0, 8'h40, 16'hBEEF);
    run_access(0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0040, 16'h0000, 4, 16'h0040, ns, ne, nw, nb, ird, mdd);
    total++; if (ns !== 3) $display("FAIL read_no_retrigger: got %0d stall cycles expected 3", ns); else passed++;
    total++; if (ne !== 2 || nb !== 0) $display("FAIL read_bus: got en=%0d bad=%0d expected 2/0", ne, nb); else passed++;
    total++; if (mdd !== 16'hBEEF) $display("FAIL read_mdr_done: got %h expected beef", mdd); else passed++;
    total++; if (ir[0] !== 16'hF123) $display("FAIL read_ir_held: got %h expected f123", ir[0]); else passed++;
  endtask

  task automatic test_write;
    int ns, ne, nw, nb;
    logic [15:0] ird, mdd;
    run_access(0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0010, 16'h0042, 16'h1234, 1, 16'h0042, ns, ne, nw, nb, ird, mdd);
    total++; if (nw !== 2 || nb !== 0) $display("FAIL write_we: got we=%0d bad=%0d expected 2/0", nw, nb); else passed++;
    total++; if (mem[0][8'h42] !== 16'h1234) $display("FAIL write_mem: got %h expected 1234", mem[0][8'h42]); else passed++;
    total++; if ({ir[0], mdr[0]} !== 32'hF123BEEF) $display("FAIL write_ir_mdr: got %h expected f123beef", {ir[0], mdr[0]}); else passed++;
    total++; if (perr[0] !== 1'b0) $display("FAIL write_perr_clean: got %b expected 0", perr[0]); else passed++;
  endtask

  task automatic test_proto_err;
    int ns, ne, nw, nb;
    logic [15:0] ird, mdd;
    run_access(0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h0050, 16'hA5A5, 1, 16'h0050, ns, ne, nw, nb, ird, mdd);
    total++; if (mem[0][8'h50] !== 16'hA5A5 || nw !== 2) $display("FAIL proto_write_done: got mem=%h we=%0d expected a5a5/2", mem[0][8'h50], nw); else passed++;
    total++; if (mdr[0] !== 16'hBEEF) $display("FAIL proto_mdr_kept: got %h expected beef", mdr[0]); else passed++;
    total++; if (perr[0] !== 1'b1) $display("FAIL proto_set: got %b expected 1", perr[0]); else passed++;
    run_access(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1, 16'h0010, ns, ne, nw, nb, ird, mdd);
    total++; if (ird !== 16'hF123 || perr[0] !== 1'b1) $display("FAIL proto_sticky: got ir=%h perr=%b expected f123/1", ird, perr[0]); else passed++;
    @(negedge CLK);
    Reset = 1'b1;
    #1;
    total++; if (perr[0] !== 1'b0) $display("FAIL proto_cleared: got %b expected 0", perr[0]); else passed++;
    @(negedge CLK);
    Reset = 1'b0;
  endtask

  task automatic test_reset_mid_access;
    int ns, ne, nw, nb, busy;
    logic [15:0] ird, mdd;
    preload(1, 8'h20, 16'h5A3C);
    preload(1, 8'h60, 16'h7777);
    run_access(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h0000, 1, 16'h0020, ns, ne, nw, nb, ird, mdd);
    total++; if (ns !== 5 || ird !== 16'h5A3C) $display("FAIL ws3_fetch: got stall=%0d ir=%h expected 5/5a3c", ns, ird); else passed++;
    @(negedge CLK);
    mrd[1] = 1'b1; msel[1] = 1'b1; alu[1] = 16'h0060;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    total++; if (en[1] !== 1'b1 || stall[1] !== 1'b1) $display("FAIL mid_busy: got en=%b stall=%b expected 1/1", en[1], stall[1]); else passed++;
    Reset = 1'b1;
    #1;
    total++; if ({en[1], we[1], stall[1]} !== 3'b000) $display("FAIL mid_reset_strobes: got %b expected 000", {en[1], we[1], stall[1]}); else passed++;
    total++; if ({ir[1], mdr[1]} !== 32'h0) $display("FAIL mid_reset_regs: got %h expected 0", {ir[1], mdr[1]}); else passed++;
    @(negedge CLK);
    drop_strobes(1);
    Reset = 1'b0;
    busy = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      #1;
      if (stall[1] || en[1]) busy++;
    end
    total++; if (busy !== 0) $display("FAIL mid_reset_idle: got %0d busy cycles expected 0", busy); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [6:0]  pat;
    logic [15:0] ir_c2, mdr_c5;
    preload(2, 8'h30, 16'h1E5A);
    preload(2, 8'h31, 16'hC0DE);
    @(negedge CLK);
    irw[2] = 1'b1; msel[2] = 1'b0; pc[2] = 16'h0030;
    pat = 7'b0; ir_c2 = 16'h0; mdr_c5 = 16'h0;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == 3) begin
        irw[2] = 1'b0; mrd[2] = 1'b1; msel[2] = 1'b1; alu[2] = 16'h0031;
      end
      if (c == 6) drop_strobes(2);
      #1;
      pat[c] = stall[2];
      if (c == 2) ir_c2 = ir[2];
      if (c == 5) mdr_c5 = mdr[2];
    end
    total++; if (pat !== 7'b0011011) $display("FAIL b2b_stall_pattern: got %b expected 0011011", pat); else passed++;
    total++; if (ir_c2 !== 16'h1E5A) $display("FAIL b2b_ir: got %h expected 1e5a", ir_c2); else passed++;
    total++; if (mdr_c5 !== 16'hC0DE) $display("FAIL b2b_mdr: got %h expected c0de", mdr_c5); else passed++;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_read_held;
    test_write;
    test_proto_err;
    test_reset_mid_access;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
